// File: rtl/scr1_dmem_arbiter_pkg.sv
// Shared memory-interface types for the SCR1 data-memory arbiter.
// - default address/data widths
// - command, width and response encodings of the SCR1 memory port
// - two-state arbiter FSM encoding, shared with IMEM-side variants
package scr1_dmem_arbiter_pkg;

  localparam int SCR1_DMEM_AWIDTH = 32;
  localparam int SCR1_DMEM_DWIDTH = 32;

  typedef enum logic [1:0] {
    SCR1_MEM_CMD_RD    = 2'b00,
    SCR1_MEM_CMD_WR    = 2'b01,
    SCR1_MEM_CMD_ERROR = 2'b11
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  // ADDR: nothing outstanding; DATA: one transaction awaiting its response
  typedef enum logic {
    SCR1_ARB_FSM_ADDR = 1'b0,
    SCR1_ARB_FSM_DATA = 1'b1
  } type_scr1_arb_fsm_e;

endpackage : scr1_dmem_arbiter_pkg

// File: rtl/scr1_arb_rr2.sv
// Two-way round-robin grant with hold.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   req[1:0]    per-requester request
//   issue_en    arbiter may issue a request this cycle
//   hs          downstream handshake (mem_req & mem_req_ack)
//   grant       index of the granted requester (combinational)
// prio_r moves only on handshake. A request that is presented but not
// accepted locks the grant to its owner until accepted or withdrawn.
module scr1_arb_rr2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       issue_en,
  input  logic       hs,
  output logic       grant
);

  logic prio_r;
  logic hold_r;
  logic hold_owner_r;
  logic hold_valid;
  logic pending;

  // A withdrawn held request releases the lock in the same cycle
  assign hold_valid = hold_r & req[hold_owner_r];
  assign pending    = issue_en & (|req) & ~hs;

  always_comb begin
    grant = prio_r;
    if (hold_valid) begin
      grant = hold_owner_r;
    end else begin
      case (req)
        2'b01:   grant = 1'b0;
        2'b10:   grant = 1'b1;
        default: grant = prio_r;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_r       <= 1'b0;
      hold_r       <= 1'b0;
      hold_owner_r <= 1'b0;
    end else if (hs) begin
      prio_r <= ~grant;
      hold_r <= 1'b0;
    end else if (pending) begin
      hold_r       <= 1'b1;
      hold_owner_r <= grant;
    end else if (hold_r & ~req[hold_owner_r]) begin
      hold_r <= 1'b0;
    end
  end

endmodule : scr1_arb_rr2

// File: rtl/scr1_dmem_arbiter.sv
// Shares one SCR1 data-memory port between the core DMEM interface (m0)
// and a secondary master (m1). One outstanding transaction; responses are
// routed to the issuing requester; round-robin with grant lock.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   mN_req/mN_req_ack               requester handshake (N = 0, 1)
//   mN_cmd/width/addr/wdata         requester request fields
//   mN_rdata/mN_resp                requester response
//   mem_req/mem_req_ack             downstream handshake
//   mem_cmd/width/addr/wdata        downstream request fields
//   mem_rdata/mem_resp              downstream response
module scr1_dmem_arbiter
  import scr1_dmem_arbiter_pkg::*;
#(
  parameter int AWIDTH = SCR1_DMEM_AWIDTH,
  parameter int DWIDTH = SCR1_DMEM_DWIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // requester 0
  input  logic                 m0_req,
  output logic                 m0_req_ack,
  input  type_scr1_mem_cmd_e   m0_cmd,
  input  type_scr1_mem_width_e m0_width,
  input  logic [AWIDTH-1:0]    m0_addr,
  input  logic [DWIDTH-1:0]    m0_wdata,
  output logic [DWIDTH-1:0]    m0_rdata,
  output type_scr1_mem_resp_e  m0_resp,
  // requester 1
  input  logic                 m1_req,
  output logic                 m1_req_ack,
  input  type_scr1_mem_cmd_e   m1_cmd,
  input  type_scr1_mem_width_e m1_width,
  input  logic [AWIDTH-1:0]    m1_addr,
  input  logic [DWIDTH-1:0]    m1_wdata,
  output logic [DWIDTH-1:0]    m1_rdata,
  output type_scr1_mem_resp_e  m1_resp,
  // downstream
  output logic                 mem_req,
  input  logic                 mem_req_ack,
  output type_scr1_mem_cmd_e   mem_cmd,
  output type_scr1_mem_width_e mem_width,
  output logic [AWIDTH-1:0]    mem_addr,
  output logic [DWIDTH-1:0]    mem_wdata,
  input  logic [DWIDTH-1:0]    mem_rdata,
  input  type_scr1_mem_resp_e  mem_resp
);

  type_scr1_arb_fsm_e fsm, fsm_next;
  logic owner_r;
  logic grant;
  logic issue_en;
  logic hs;

  // Issue is allowed when idle or when the outstanding transaction completes
  // OK this cycle. Gated by rst_n so no request leaks out while in reset.
  assign issue_en = rst_n & ((fsm == SCR1_ARB_FSM_ADDR) |
                             ((fsm == SCR1_ARB_FSM_DATA) & (mem_resp == SCR1_MEM_RESP_RDY_OK)));
  assign hs       = mem_req & mem_req_ack;

  scr1_arb_rr2 i_rr2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      ({m1_req, m0_req}),
    .issue_en (issue_en),
    .hs       (hs),
    .grant    (grant)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm     <= SCR1_ARB_FSM_ADDR;
      owner_r <= 1'b0;
    end else begin
      fsm <= fsm_next;
      if (hs) owner_r <= grant;
    end
  end

  // Next state
  always_comb begin
    fsm_next = fsm;
    case (fsm)
      SCR1_ARB_FSM_ADDR: begin
        if (hs) fsm_next = SCR1_ARB_FSM_DATA;
      end
      SCR1_ARB_FSM_DATA: begin
        case (mem_resp)
          SCR1_MEM_RESP_RDY_OK: fsm_next = hs ? SCR1_ARB_FSM_DATA : SCR1_ARB_FSM_ADDR;
          SCR1_MEM_RESP_RDY_ER: fsm_next = SCR1_ARB_FSM_ADDR;
          default:              fsm_next = SCR1_ARB_FSM_DATA;
        endcase
      end
      default: fsm_next = SCR1_ARB_FSM_ADDR;
    endcase
  end

  // Outputs: request mux, acks, response routing
  always_comb begin
    mem_req    = issue_en & (m0_req | m1_req);
    mem_cmd    = SCR1_MEM_CMD_ERROR;
    mem_width  = SCR1_MEM_WIDTH_ERROR;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (mem_req) begin
      mem_cmd   = grant ? m1_cmd   : m0_cmd;
      mem_width = grant ? m1_width : m0_width;
      mem_addr  = grant ? m1_addr  : m0_addr;
      mem_wdata = grant ? m1_wdata : m0_wdata;
    end

    m0_req_ack = issue_en & ~grant & mem_req_ack;
    m1_req_ack = issue_en &  grant & mem_req_ack;

    m0_resp  = SCR1_MEM_RESP_NOTRDY;
    m1_resp  = SCR1_MEM_RESP_NOTRDY;
    m0_rdata = '0;
    m1_rdata = '0;
    if (fsm == SCR1_ARB_FSM_DATA) begin
      if (owner_r) begin
        m1_resp  = mem_resp;
        m1_rdata = mem_rdata;
      end else begin
        m0_resp  = mem_resp;
        m0_rdata = mem_rdata;
      end
    end
  end

endmodule : scr1_dmem_arbiter

// File: tb/tb_scr1_dmem_arbiter.sv
// Directed bench for scr1_dmem_arbiter. Inputs change just after each
// rising edge; combinational outputs are checked before the next edge.
module tb_scr1_dmem_arbiter;
  import scr1_dmem_arbiter_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 m0_req, m1_req, m0_req_ack, m1_req_ack;
  type_scr1_mem_cmd_e   m0_cmd, m1_cmd, mem_cmd;
  type_scr1_mem_width_e m0_width, m1_width, mem_width;
  logic [31:0]          m0_addr, m1_addr, mem_addr;
  logic [31:0]          m0_wdata, m1_wdata, mem_wdata;
  logic [31:0]          m0_rdata, m1_rdata, mem_rdata;
  type_scr1_mem_resp_e  m0_resp, m1_resp, mem_resp;
  logic                 mem_req, mem_req_ack;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  scr1_dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_req_ack(m0_req_ack), .m0_cmd(m0_cmd), .m0_width(m0_width),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_resp(m0_resp),
    .m1_req(m1_req), .m1_req_ack(m1_req_ack), .m1_cmd(m1_cmd), .m1_width(m1_width),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_resp(m1_resp),
    .mem_req(mem_req), .mem_req_ack(mem_req_ack), .mem_cmd(mem_cmd), .mem_width(mem_width),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // settle combinational outputs after driving inputs
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m1_req = 0; mem_req_ack = 0;
    m0_cmd = SCR1_MEM_CMD_RD; m1_cmd = SCR1_MEM_CMD_RD;
    m0_width = SCR1_MEM_WIDTH_WORD; m1_width = SCR1_MEM_WIDTH_WORD;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    mem_rdata = 0; mem_resp = SCR1_MEM_RESP_NOTRDY;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
  endtask

  initial begin
    logic [31:0] ct_addr [3];
    logic [31:0] ct_data [3];
    ct_addr[0] = 32'h200; ct_addr[1] = 32'h300; ct_addr[2] = 32'h200;
    ct_data[0] = 32'h11;  ct_data[1] = 32'h22;  ct_data[2] = 32'h33;

    // ---- reset state ----
    idle_inputs();
    rst_n = 0;
    tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_m0_ack", m0_req_ack, 0);
    chk("rst_m1_ack", m1_req_ack, 0);
    chk("rst_m0_resp", m0_resp, SCR1_MEM_RESP_NOTRDY);
    chk("rst_m1_resp", m1_resp, SCR1_MEM_RESP_NOTRDY);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_mem_cmd", mem_cmd, SCR1_MEM_CMD_ERROR);
    chk("rst_mem_width", mem_width, SCR1_MEM_WIDTH_ERROR);
    chk("rst_mem_addr", mem_addr, 0);
    rst_n = 1;
    tick();

    // ---- single read by m0 ----
    m0_req = 1; m0_addr = 32'h100; mem_req_ack = 1;
    settle();
    chk("rd_mem_req", mem_req, 1);
    chk("rd_mem_addr", mem_addr, 32'h100);
    chk("rd_mem_cmd", mem_cmd, SCR1_MEM_CMD_RD);
    chk("rd_mem_width", mem_width, SCR1_MEM_WIDTH_WORD);
    chk("rd_m0_ack", m0_req_ack, 1);
    chk("rd_m1_ack", m1_req_ack, 0);
    tick();
    m0_req = 0; mem_req_ack = 0; mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'hDEADBEEF;
    settle();
    chk("rd_m0_resp", m0_resp, SCR1_MEM_RESP_RDY_OK);
    chk("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd_m1_resp", m1_resp, SCR1_MEM_RESP_NOTRDY);
    chk("rd_m1_rdata", m1_rdata, 0);
    chk("rd_idle_mem_req", mem_req, 0);
    tick();
    mem_resp = SCR1_MEM_RESP_NOTRDY;
    settle();
    chk("rd_after_m0_resp", m0_resp, SCR1_MEM_RESP_NOTRDY);

    // ---- contention: grants 0,1,0,1, one per cycle ----
    do_reset();
    m0_req = 1; m1_req = 1; m0_addr = 32'h200; m1_addr = 32'h300; mem_req_ack = 1;
    settle();
    chk("ct0_mem_addr", mem_addr, 32'h200);
    chk("ct0_m0_ack", m0_req_ack, 1);
    chk("ct0_m1_ack", m1_req_ack, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = ct_data[i];
      settle();
      // transaction i was issued by requester i%2; next grant goes to the other
      if (i % 2 == 0) begin
        chk("ct_m0_resp", m0_resp, SCR1_MEM_RESP_RDY_OK);
        chk("ct_m0_rdata", m0_rdata, ct_data[i]);
        chk("ct_m1_resp", m1_resp, SCR1_MEM_RESP_NOTRDY);
        chk("ct_m1_ack", m1_req_ack, 1);
        chk("ct_m0_ack", m0_req_ack, 0);
        chk("ct_mem_addr", mem_addr, 32'h300);
      end else begin
        chk("ct_m1_resp", m1_resp, SCR1_MEM_RESP_RDY_OK);
        chk("ct_m1_rdata", m1_rdata, ct_data[i]);
        chk("ct_m0_resp", m0_resp, SCR1_MEM_RESP_NOTRDY);
        chk("ct_m0_ack", m0_req_ack, 1);
        chk("ct_m1_ack", m1_req_ack, 0);
        chk("ct_mem_addr", mem_addr, ct_addr[i+1]);
      end
    end

    // ---- grant lock ----
    do_reset();
    m1_req = 1; m1_addr = 32'h400;
    settle();
    chk("gl1_mem_req", mem_req, 1);
    chk("gl1_mem_addr", mem_addr, 32'h400);
    chk("gl1_m1_ack", m1_req_ack, 0);
    tick();
    m0_req = 1; m0_addr = 32'h500;
    settle();
    chk("gl2_mem_addr", mem_addr, 32'h400);
    chk("gl2_m0_ack", m0_req_ack, 0);
    tick();
    settle();
    chk("gl3_mem_addr", mem_addr, 32'h400);
    tick();
    mem_req_ack = 1;
    settle();
    chk("gl4_mem_addr", mem_addr, 32'h400);
    chk("gl4_m1_ack", m1_req_ack, 1);
    chk("gl4_m0_ack", m0_req_ack, 0);
    tick();
    m1_req = 0; mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'h44;
    settle();
    chk("gl5_m1_resp", m1_resp, SCR1_MEM_RESP_RDY_OK);
    chk("gl5_m1_rdata", m1_rdata, 32'h44);
    chk("gl5_mem_addr", mem_addr, 32'h500);
    chk("gl5_m0_ack", m0_req_ack, 1);

    // ---- error response ----
    do_reset();
    m0_req = 1; m0_cmd = SCR1_MEM_CMD_WR; m0_addr = 32'h600; m0_wdata = 32'hCAFE;
    m1_req = 1; m1_addr = 32'h700; mem_req_ack = 1;
    settle();
    chk("er1_mem_cmd", mem_cmd, SCR1_MEM_CMD_WR);
    chk("er1_mem_wdata", mem_wdata, 32'hCAFE);
    chk("er1_m0_ack", m0_req_ack, 1);
    tick();
    m0_req = 0; mem_resp = SCR1_MEM_RESP_RDY_ER;
    settle();
    chk("er2_m0_resp", m0_resp, SCR1_MEM_RESP_RDY_ER);
    chk("er2_m1_resp", m1_resp, SCR1_MEM_RESP_NOTRDY);
    chk("er2_mem_req", mem_req, 0);
    chk("er2_m1_ack", m1_req_ack, 0);
    tick();
    mem_resp = SCR1_MEM_RESP_NOTRDY;
    settle();
    chk("er3_mem_req", mem_req, 1);
    chk("er3_mem_addr", mem_addr, 32'h700);
    chk("er3_mem_cmd", mem_cmd, SCR1_MEM_CMD_RD);
    chk("er3_m1_ack", m1_req_ack, 1);

    // ---- wait states ----
    do_reset();
    m0_req = 1; m0_addr = 32'h800; mem_req_ack = 1;
    settle();
    chk("ws0_m0_ack", m0_req_ack, 1);
    tick();
    m1_req = 1; m1_addr = 32'h900;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("ws_mem_req", mem_req, 0);
      chk("ws_m0_ack", m0_req_ack, 0);
      chk("ws_m1_ack", m1_req_ack, 0);
      chk("ws_m0_resp", m0_resp, SCR1_MEM_RESP_NOTRDY);
      tick();
    end
    mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'h55;
    settle();
    chk("ws_done_m0_resp", m0_resp, SCR1_MEM_RESP_RDY_OK);
    chk("ws_done_m0_rdata", m0_rdata, 32'h55);
    chk("ws_done_mem_req", mem_req, 1);
    chk("ws_done_m1_ack", m1_req_ack, 1);
    chk("ws_done_mem_addr", mem_addr, 32'h900);

    // ---- reset mid-operation ----
    do_reset();
    m0_req = 1; m0_addr = 32'hA00; mem_req_ack = 1;
    settle();
    chk("rm0_m0_ack", m0_req_ack, 1);
    tick();
    rst_n = 0; mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'h66;
    settle();
    chk("rm_m0_resp", m0_resp, SCR1_MEM_RESP_NOTRDY);
    chk("rm_m0_rdata", m0_rdata, 0);
    chk("rm_mem_req", mem_req, 0);
    chk("rm_m0_ack", m0_req_ack, 0);
    chk("rm_mem_cmd", mem_cmd, SCR1_MEM_CMD_ERROR);
    tick();
    rst_n = 1; m0_req = 0;
    settle();
    chk("rm_late_m0_resp", m0_resp, SCR1_MEM_RESP_NOTRDY);
    chk("rm_late_m1_resp", m1_resp, SCR1_MEM_RESP_NOTRDY);
    chk("rm_late_m0_rdata", m0_rdata, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_scr1_dmem_arbiter
